// File: rtl/exu_div_seq_pkg.sv
// Shared definitions for the exu_div_seq divide sequencer.
//   - i_op bit positions (unsigned, remainder, word)
//   - FSM state encoding
//   - div_wext: sign-extends a 32-bit word-op result to 64 bits
package exu_div_seq_pkg;

    localparam int DIV_OP_UNSIGNED = 0;
    localparam int DIV_OP_REM      = 1;
    localparam int DIV_OP_WORD     = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Every W op returns its 32-bit result sign-extended, the unsigned ones included.
    function automatic logic [63:0] div_wext(input logic word, input logic [63:0] v);
        return word ? {{32{v[31]}}, v[31:0]} : v;
    endfunction

endpackage

// File: rtl/exu_div_seq_div_iter_step.sv
// One radix-2 restoring divide step (combinational).
// Ports:
//   i_rem, i_q : current partial remainder and quotient/dividend shift register
//   i_div      : divisor magnitude
//   o_rem, o_q : values after shifting {rem,q} left by one and a conditional subtract
module div_iter_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_q,
    input  logic [XLEN-1:0] i_div,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_q
);

    // The shifted remainder needs one extra bit: it can reach 2*divisor-1.
    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_diff;

    // Shift, trial-subtract, keep the difference when it does not go negative.
    always_comb begin
        w_shift = {i_rem, i_q[XLEN-1]};
        w_diff  = w_shift - {1'b0, i_div};
        if (w_shift >= {1'b0, i_div}) begin
            o_rem = w_diff[XLEN-1:0];
            o_q   = {i_q[XLEN-2:0], 1'b1};
        end else begin
            o_rem = w_shift[XLEN-1:0];
            o_q   = {i_q[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/exu_div_seq.sv
// Multi-cycle RV64M divide/remainder sequencer (DIV/DIVU/REM/REMU and W forms).
// Ports:
//   i_clk, i_rst_n        : clock, async active-low reset
//   i_valid/o_ready       : request handshake; i_op, i_src1 (dividend), i_src2 (divisor)
//   i_flush               : abort anything in flight, highest priority
//   o_valid/i_ready       : result handshake; o_result is quotient or remainder
// Optional macro EXU_DIV_PAIR_CACHE_EN: remembers the last computed quotient/remainder pair
// so a following DIV/REM on identical operands completes in one cycle.
module exu_div_seq
    import exu_div_seq_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 6
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_src1,
    input  logic [XLEN-1:0] i_src2,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result
);

    div_state_e      r_state;
    div_state_e      w_state_nxt;
    logic            r_ready;
    logic            r_valid;
    logic [XLEN-1:0] r_result;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_q;
    logic [XLEN-1:0] r_div;
    logic            r_q_neg;
    logic            r_r_neg;
    logic            r_is_rem;
    logic            r_word;

    logic            w_uns, w_rem_op, w_word, w_accept;
    logic [XLEN-1:0] w_a, w_b, w_a_abs, w_b_abs, w_q_pre, w_spec_res;
    logic            w_a_neg, w_b_neg, w_div0, w_ovf, w_special;
    logic [XLEN-1:0] w_rem_nxt, w_q_nxt, w_q_fin, w_r_fin, w_calc_res;
    logic            w_hit;
    logic [XLEN-1:0] w_hit_res;

    assign o_ready  = r_ready;
    assign o_valid  = r_valid;
    assign o_result = r_result;

    assign w_uns    = i_op[DIV_OP_UNSIGNED];
    assign w_rem_op = i_op[DIV_OP_REM];
    assign w_word   = i_op[DIV_OP_WORD];
    assign w_accept = (r_state == IDLE) & i_valid & ~i_flush;

    // Operand extension, magnitudes and special-case detection at accept time.
    always_comb begin
        if (w_word) begin
            w_a = w_uns ? {32'h0, i_src1[31:0]} : {{32{i_src1[31]}}, i_src1[31:0]};
            w_b = w_uns ? {32'h0, i_src2[31:0]} : {{32{i_src2[31]}}, i_src2[31:0]};
            w_ovf = ~w_uns & (i_src1[31:0] == 32'h8000_0000) & (i_src2[31:0] == 32'hFFFF_FFFF);
        end else begin
            w_a = i_src1;
            w_b = i_src2;
            w_ovf = ~w_uns & (i_src1 == {1'b1, {(XLEN-1){1'b0}}}) & (i_src2 == {XLEN{1'b1}});
        end
        w_a_neg   = ~w_uns & w_a[XLEN-1];
        w_b_neg   = ~w_uns & w_b[XLEN-1];
        w_a_abs   = w_a_neg ? ({XLEN{1'b0}} - w_a) : w_a;
        w_b_abs   = w_b_neg ? ({XLEN{1'b0}} - w_b) : w_b;
        w_div0    = (w_b == {XLEN{1'b0}});
        w_special = w_div0 | w_ovf;
        // Word ops park the dividend in the top half so 32 shifts consume exactly it.
        w_q_pre   = w_word ? {w_a_abs[31:0], 32'h0} : w_a_abs;
        if (w_div0) begin
            w_spec_res = div_wext(w_word, w_rem_op ? w_a : {XLEN{1'b1}});
        end else begin
            w_spec_res = div_wext(w_word, w_rem_op ? {XLEN{1'b0}} : w_a);
        end
    end

    div_iter_step #(.XLEN(XLEN)) u_step (
        .i_rem (r_rem),
        .i_q   (r_q),
        .i_div (r_div),
        .o_rem (w_rem_nxt),
        .o_q   (w_q_nxt)
    );

    // Sign correction of the final step's outputs.
    always_comb begin
        w_q_fin    = div_wext(r_word, r_q_neg ? ({XLEN{1'b0}} - w_q_nxt) : w_q_nxt);
        w_r_fin    = div_wext(r_word, r_r_neg ? ({XLEN{1'b0}} - w_rem_nxt) : w_rem_nxt);
        w_calc_res = r_is_rem ? w_r_fin : w_q_fin;
    end

`ifdef EXU_DIV_PAIR_CACHE_EN
    logic            r_c_vld, r_c_word, r_c_uns;
    logic [XLEN-1:0] r_c_a, r_c_b, r_c_q, r_c_r;
    logic            r_uns;
    logic [XLEN-1:0] r_a, r_b;

    // Cache lookup against the incoming request.
    always_comb begin
        w_hit     = r_c_vld & (r_c_word == w_word) & (r_c_uns == w_uns) &
                    (r_c_a == w_a) & (r_c_b == w_b);
        w_hit_res = w_rem_op ? r_c_r : r_c_q;
    end

    // Cache fill on normal-path completion; flush drops it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_c_vld  <= 1'b0;
            r_c_word <= 1'b0;
            r_c_uns  <= 1'b0;
            r_c_a    <= {XLEN{1'b0}};
            r_c_b    <= {XLEN{1'b0}};
            r_c_q    <= {XLEN{1'b0}};
            r_c_r    <= {XLEN{1'b0}};
            r_uns    <= 1'b0;
            r_a      <= {XLEN{1'b0}};
            r_b      <= {XLEN{1'b0}};
        end else if (i_flush) begin
            r_c_vld  <= 1'b0;
        end else if (w_accept) begin
            r_uns    <= w_uns;
            r_a      <= w_a;
            r_b      <= w_b;
        end else if ((r_state == CALC) && (r_cnt == {CNT_W{1'b0}})) begin
            r_c_vld  <= 1'b1;
            r_c_word <= r_word;
            r_c_uns  <= r_uns;
            r_c_a    <= r_a;
            r_c_b    <= r_b;
            r_c_q    <= w_q_fin;
            r_c_r    <= w_r_fin;
        end
    end
`else
    assign w_hit     = 1'b0;
    assign w_hit_res = {XLEN{1'b0}};
`endif

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (i_flush) begin
                    w_state_nxt = IDLE;
                end else if (i_valid) begin
                    w_state_nxt = (w_special | w_hit) ? DONE : CALC;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            CALC: begin
                if (i_flush) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == {CNT_W{1'b0}}) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = CALC;
                end
            end
            DONE: begin
                if (i_flush || i_ready) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register with handshake outputs registered from the next state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == IDLE);
            r_valid <= (w_state_nxt == DONE);
        end
    end

    // Datapath: operand latch, iteration, and result capture on entry to DONE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_result <= {XLEN{1'b0}};
            r_cnt    <= {CNT_W{1'b0}};
            r_rem    <= {XLEN{1'b0}};
            r_q      <= {XLEN{1'b0}};
            r_div    <= {XLEN{1'b0}};
            r_q_neg  <= 1'b0;
            r_r_neg  <= 1'b0;
            r_is_rem <= 1'b0;
            r_word   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_is_rem <= w_rem_op;
                        r_word   <= w_word;
                        r_q_neg  <= w_a_neg ^ w_b_neg;
                        r_r_neg  <= w_a_neg;
                        r_div    <= w_b_abs;
                        r_rem    <= {XLEN{1'b0}};
                        r_q      <= w_q_pre;
                        r_cnt    <= w_word ? CNT_W'(31) : CNT_W'(XLEN - 1);
                        if (w_special) begin
                            r_result <= w_spec_res;
                        end else if (w_hit) begin
                            r_result <= w_hit_res;
                        end
                    end
                end
                CALC: begin
                    if (!i_flush) begin
                        r_rem <= w_rem_nxt;
                        r_q   <= w_q_nxt;
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == {CNT_W{1'b0}}) begin
                            r_result <= w_calc_res;
                        end
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

endmodule
